vm_purchase_ctrl: RTL
=====================

// Module: vm_purchase_ctrl
// PURPOSE
//  Clocked purchase sequencer for the vending machine. Owns the slot table {tag[7:6],count[5:3],price[2:0]}.
//  Accumulates coin credit, checks a selection against stock and price, and decrements stock.
//  Dispenses items one per handshake, then returns change. Restock/config writes share the table, idle only.
// PARAMETERS
//  SLOTS     4    number of slot-table entries (address = sel_tag)
//  MONEY_W   4    credit/coin/change width; credit saturates at 2**MONEY_W-1
//  TIMEOUT   200  COLLECT idle cycles before auto-refund; 0 disables
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  coin_valid     in   1        one coin per asserted cycle
//  coin_value     in   MONEY_W  coin value
//  coin_reject    out  1        1-cycle pulse: coin not credited
//  sel_valid      in   1        selection request
//  sel_tag        in   2        slot address
//  sel_count      in   3        items requested
//  cancel         in   1        refund request
//  grant          out  1        1-cycle pulse: purchase accepted
//  deny           out  1        1-cycle pulse: purchase refused
//  disp_valid     out  1        item ready to drop
//  disp_tag       out  2        tag field of dispensed item
//  disp_ready     in   1        mechanism accepts item
//  change_valid   out  1        1-cycle pulse with change_amount
//  change_amount  out  MONEY_W  refund/change value
//  cfg_we         in   1        table write strobe
//  cfg_addr       in   2        table address
//  cfg_data       in   8        {tag,count,price}
//  cfg_busy       out  1        1 when state!=IDLE; writes dropped
//  busy           out  1        1 when state!=IDLE
// BEHAVIOUR
//  Reset: state=IDLE, credit=0, table entries=0, all outputs 0. Reset mid-transaction aborts it; credit is lost.
//  States: IDLE, COLLECT, CHECK, DISPENSE, CHANGE.
//  IDLE:   cfg_we writes table[cfg_addr] next edge. Coin -> credit=coin, COLLECT.
//          sel_valid -> CHECK, so a zero-credit sel is denied via CHECK. cfg_we has priority over coin/sel;
//          coin/sel in that cycle are dropped, coin_reject pulses.
//  COLLECT priority: cancel > sel_valid > coin.
//    cancel -> CHANGE. sel -> CHECK; a coin in the same cycle is rejected.
//    coin: credit+coin > max -> coin_reject, credit unchanged; else add. Any coin or sel restarts the timeout.
//    Timeout expiry -> CHANGE.
//  CHECK (1 cycle): cost = sel_count*price (6-bit, no truncation).
//    grant iff sel_count!=0 && sel_count<=count && credit>=cost.
//    Selection is latched at entry; inputs are ignored during CHECK.
//    grant: table count-=sel_count, credit-=cost, remaining=sel_count, DISPENSE.
//    deny: credit unchanged; -> COLLECT if credit>0, else IDLE.
//  DISPENSE: disp_valid=1, disp_tag stable until disp_ready. Each handshake decrements remaining.
//    Same-cycle re-issue of the next item is allowed. After the last handshake: credit>0 -> CHANGE, else IDLE.
//    cancel, sel and coins are ignored; coins are rejected.
//  CHANGE (1 cycle): change_valid=1, change_amount=credit, credit=0, -> IDLE.
//  coin_reject fires for every coin_valid not credited, in any state.
//  grant/deny/change_valid are registered outputs, asserted in the cycle after the deciding edge.
// STRUCTURE
//  vm_pkg: state enum, MONEY_W, field slices TAG/COUNT/PRICE, entry width 8.
//  Sub-module vm_slot_table:
//    - SLOTS x 8 registers, async-reset to 0, one combinational read port.
//    - One write port muxing cfg write and grant decrement; these are mutually exclusive by state.
//  Top: FSM, credit register, remaining counter, timeout counter.
// TESTING
//  Config slot1={01,101,010}. Coins 5,4 -> sel tag1 cnt2 -> grant.
//    Then 2 handshakes; table count 3; change_amount 5.
//  Credit 3, sel tag1 cnt2 (cost 4) -> deny; state COLLECT, credit 3. Then cancel -> change_amount 3.
//  Credit 14, coin 2 -> coin_reject, credit stays 14. sel cnt 6 (stock 5) -> deny.
//  disp_ready held low 10 cycles -> disp_valid and disp_tag stable throughout; coin during DISPENSE -> rejected.
//  cfg_we during DISPENSE -> dropped, table unchanged. TIMEOUT=8, credit 4, idle 8 cycles -> change_amount 4.
//  rst_n low mid-DISPENSE -> all outputs 0 immediately; IDLE after release; table reads 0.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine purchase sequencer.
// The slot-table entry layout is {tag[7:6], count[5:3], price[2:0]}.
package vm_pkg;

  localparam int MONEY_W = 4;
  localparam int ENTRY_W = 8;

  localparam int TAG_MSB   = 7;
  localparam int TAG_LSB   = 6;
  localparam int COUNT_MSB = 5;
  localparam int COUNT_LSB = 3;
  localparam int PRICE_MSB = 2;
  localparam int PRICE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_DISPENSE,
    ST_CHANGE
  } state_t;

  typedef struct packed {
    logic [TAG_MSB-TAG_LSB:0]     tag;
    logic [COUNT_MSB-COUNT_LSB:0] count;
    logic [PRICE_MSB-PRICE_LSB:0] price;
  } slot_t;

  // Full-width product: 7*7 = 49 still fits in 6 bits.
  function automatic logic [5:0] cost_of(input logic [2:0] n, input logic [2:0] price);
    return {3'b000, n} * {3'b000, price};
  endfunction

endpackage

// File: rtl/vm_slot_table.sv
// Slot table: SLOTS x 8-bit register file, one combinational read port and one
// write port shared by configuration writes and the stock decrement on grant.
module vm_slot_table
  import vm_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  slot_t         cfg_data,
  input  logic          dec_we,
  input  logic [AW-1:0] dec_addr,
  input  logic [2:0]    dec_count,
  input  logic [AW-1:0] rd_addr,
  output slot_t         rd_data
);

  slot_t         entries [SLOTS];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  slot_t         wr_data;

  // The controller only raises dec_we in CHECK and cfg_we in IDLE, so the
  // two sources never collide.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_en   = cfg_we | dec_we;
    wr_addr = cfg_addr;
    wr_data = cfg_data;
    if (dec_we) begin
      wr_addr       = dec_addr;
      wr_data       = entries[dec_addr];
      wr_data.count = entries[dec_addr].count - dec_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is built from flops, so the async reset clears every entry.
      for (int i = 0; i < SLOTS; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_addr] <= wr_data;
    end
  end

  assign rd_data = entries[rd_addr];

endmodule

// File: rtl/vm_purchase_ctrl.sv
// Purchase sequencer: coin credit, stock/price check, item dispense handshake
// and change return, sharing the slot table with restock/config writes.
module vm_purchase_ctrl
  import vm_pkg::*;
#(
  parameter int SLOTS   = 4,
  parameter int MONEY_W = vm_pkg::MONEY_W,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  output logic               coin_reject,
  input  logic               sel_valid,
  input  logic [1:0]         sel_tag,
  input  logic [2:0]         sel_count,
  input  logic               cancel,
  output logic               grant,
  output logic               deny,
  output logic               disp_valid,
  output logic [1:0]         disp_tag,
  input  logic               disp_ready,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amount,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_data,
  output logic               cfg_busy,
  output logic               busy
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  logic [MONEY_W-1:0] credit;
  logic [2:0]         remaining;
  logic [1:0]         sel_tag_q;
  logic [2:0]         sel_count_q;
  logic [TMR_W-1:0]   tmr;

  slot_t              rd_entry;
  logic [5:0]         cost;
  logic               grant_ok;
  logic [MONEY_W:0]   coin_sum;
  logic               coin_fits;
  logic               tmo_hit;
  logic               tbl_cfg_we;
  logic               tbl_dec_we;

  assign cost      = cost_of(sel_count_q, rd_entry.price);
  assign grant_ok  = (sel_count_q != 3'd0) && (sel_count_q <= rd_entry.count) &&
                     (32'(credit) >= 32'(cost));
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits = !coin_sum[MONEY_W];
  assign tmo_hit   = (TIMEOUT != 0) && (tmr == TMR_W'(TIMEOUT - 1));

  assign tbl_cfg_we = cfg_we && (state == ST_IDLE);
  assign tbl_dec_we = (state == ST_CHECK) && grant_ok;

  vm_slot_table #(
    .SLOTS (SLOTS),
    .AW    (2)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (tbl_cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .dec_we    (tbl_dec_we),
    .dec_addr  (sel_tag_q),
    .dec_count (sel_count_q),
    .rd_addr   (sel_tag_q),
    .rd_data   (rd_entry)
  );

  assign busy     = (state != ST_IDLE);
  assign cfg_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      credit        <= '0;
      remaining     <= '0;
      sel_tag_q     <= '0;
      sel_count_q   <= '0;
      tmr           <= '0;
      coin_reject   <= 1'b0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      disp_valid    <= 1'b0;
      disp_tag      <= '0;
      change_valid  <= 1'b0;
      change_amount <= '0;
    end else begin
      // NOTE: state uses <= only, so every branch below sees pre-edge values.
      coin_reject   <= 1'b0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;

      unique case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            coin_reject <= coin_valid;
          end else if (sel_valid) begin
            sel_tag_q   <= sel_tag;
            sel_count_q <= sel_count;
            coin_reject <= coin_valid;
            state       <= ST_CHECK;
          end else if (coin_valid) begin
            credit <= coin_value;
            tmr    <= '0;
            state  <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (cancel) begin
            coin_reject   <= coin_valid;
            change_valid  <= 1'b1;
            change_amount <= credit;
            state         <= ST_CHANGE;
          end else if (sel_valid) begin
            sel_tag_q   <= sel_tag;
            sel_count_q <= sel_count;
            coin_reject <= coin_valid;
            state       <= ST_CHECK;
          end else if (coin_valid) begin
            // A refused coin still counts as activity for the timeout.
            tmr <= '0;
            if (coin_fits) credit <= coin_sum[MONEY_W-1:0];
            else           coin_reject <= 1'b1;
          end else if (tmo_hit) begin
            change_valid  <= 1'b1;
            change_amount <= credit;
            state         <= ST_CHANGE;
          end else if (TIMEOUT != 0) begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        ST_CHECK: begin
          coin_reject <= coin_valid;
          if (grant_ok) begin
            grant      <= 1'b1;
            credit     <= credit - MONEY_W'(cost);
            remaining  <= sel_count_q;
            disp_valid <= 1'b1;
            disp_tag   <= rd_entry.tag;
            state      <= ST_DISPENSE;
          end else begin
            deny  <= 1'b1;
            tmr   <= '0;
            state <= (credit != '0) ? ST_COLLECT : ST_IDLE;
          end
        end

        ST_DISPENSE: begin
          coin_reject <= coin_valid;
          if (disp_ready) begin
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
              disp_valid <= 1'b0;
              disp_tag   <= '0;
              if (credit != '0) begin
                change_valid  <= 1'b1;
                change_amount <= credit;
                state         <= ST_CHANGE;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end

        ST_CHANGE: begin
          coin_reject <= coin_valid;
          credit      <= '0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
